// File: rtl/des_block_packer.sv
// Packs pairs of 32-bit PipeIn words into 64-bit DES input blocks (first word low)
// and buffers them in a first-word-fall-through FIFO with a valid/ready head.
module des_block_packer #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [31:0] PAD_WORD   = 32'h0000_0000
) (
   input  logic                  okClk,
   input  logic                  reset_n,
   input  logic                  ram_reset,
   input  logic                  pipe_write,
   input  logic [31:0]           pipe_data,
   input  logic                  flush,
   output logic                  blk_valid,
   output logic [63:0]           blk_data,
   input  logic                  blk_ready,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  half_pending,
   output logic                  overflow,
   output logic [15:0]           blocks_in
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {S_LOW, S_HIGH} state_t;

   state_t                  state_reg, state_next;
   logic [31:0]             half_reg, half_next;
   logic                    push_req;
   logic [63:0]             push_data;
   logic                    pop, push_ok, drop, wr_en;

   logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [DEPTH_LOG2:0]     level_reg, level_next;
   logic                    full_reg, empty_reg, overflow_reg;
   logic [15:0]             blocks_in_reg;
   logic [63:0]             mem_reg [DEPTH];

   // Packer: decides whether this cycle completes a block and what it holds
   always_comb begin
      state_next = state_reg;
      half_next  = half_reg;
      push_req   = 1'b0;
      push_data  = {PAD_WORD, half_reg};
      case (state_reg)
         S_LOW: begin
            if (pipe_write && flush) begin
               push_req  = 1'b1;
               push_data = {PAD_WORD, pipe_data};
            end else if (pipe_write) begin
               half_next  = pipe_data;
               state_next = S_HIGH;
            end
         end
         S_HIGH: begin
            if (pipe_write) begin
               push_req   = 1'b1;
               push_data  = {pipe_data, half_reg};
               state_next = S_LOW;
            end else if (flush) begin
               push_req   = 1'b1;
               push_data  = {PAD_WORD, half_reg};
               state_next = S_LOW;
            end
         end
         default: state_next = S_LOW;
      endcase
   end

   assign pop     = !empty_reg && blk_ready;
   assign push_ok = push_req && (!full_reg || pop);
   assign drop    = push_req && !push_ok;
   assign wr_en   = push_ok && !ram_reset;

   always_comb begin
      level_next = level_reg;
      if (push_ok && !pop)
         level_next = level_reg + (DEPTH_LOG2+1)'(1);
      else if (pop && !push_ok)
         level_next = level_reg - (DEPTH_LOG2+1)'(1);
   end

   always_ff @(posedge okClk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_LOW;
         half_reg      <= 32'h0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         overflow_reg  <= 1'b0;
         blocks_in_reg <= 16'h0;
      end else if (ram_reset) begin
         state_reg     <= S_LOW;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         overflow_reg  <= 1'b0;
         blocks_in_reg <= 16'h0;
      end else begin
         state_reg <= state_next;
         half_reg  <= half_next;
         level_reg <= level_next;
         // Flags are derived from the next level so they never lag it
         full_reg  <= (level_next == (DEPTH_LOG2+1)'(DEPTH));
         empty_reg <= (level_next == '0);
         if (drop)
            overflow_reg <= 1'b1;
         if (push_ok) begin
            wr_ptr_reg    <= wr_ptr_reg + DEPTH_LOG2'(1);
            blocks_in_reg <= blocks_in_reg + 16'd1;
         end
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
   end

   // Per-entry registers so the storage can be cleared by reset
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge okClk or negedge reset_n) begin
         if (!reset_n)
            mem_reg[gi] <= 64'h0;
         else if (wr_en && (wr_ptr_reg == DEPTH_LOG2'(gi)))
            mem_reg[gi] <= push_data;
      end
   end

   assign blk_data     = mem_reg[rd_ptr_reg];
   assign blk_valid    = !empty_reg;
   assign full         = full_reg;
   assign empty        = empty_reg;
   assign level        = level_reg;
   assign half_pending = (state_reg == S_HIGH);
   assign overflow     = overflow_reg;
   assign blocks_in    = blocks_in_reg;

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: directed scenarios plus random traffic, checked against
// a queue-based model of the packer and FIFO.
module tb_des_block_packer;

   localparam logic [31:0] PAD = 32'h0000_0000;
   localparam int          DEP = 16;

   logic        okClk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ram_reset = 1'b0;
   logic        pipe_write = 1'b0;
   logic [31:0] pipe_data = 32'h0;
   logic        flush = 1'b0;
   logic        blk_ready = 1'b0;
   logic        blk_valid, full, empty, half_pending, overflow;
   logic [63:0] blk_data;
   logic [4:0]  level;
   logic [15:0] blocks_in;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [63:0] q[$];
   bit          m_pend = 0;
   logic [31:0] m_word = 32'h0;
   bit          m_ovf = 0;
   logic [15:0] m_bin = 16'h0;

   des_block_packer #(.DEPTH_LOG2(4), .PAD_WORD(PAD)) dut (
      .okClk(okClk), .reset_n(reset_n), .ram_reset(ram_reset),
      .pipe_write(pipe_write), .pipe_data(pipe_data), .flush(flush),
      .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
      .full(full), .empty(empty), .level(level), .half_pending(half_pending),
      .overflow(overflow), .blocks_in(blocks_in)
   );

   always #5 okClk = ~okClk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pend = 0;
      m_word = 32'h0;
      m_ovf  = 0;
      m_bin  = 16'h0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      bit          do_push;
      bit          do_pop;
      bit          was_full;
      logic [63:0] blk;
      if (ram_reset) begin
         q.delete();
         m_pend = 0;
         m_ovf  = 0;
         m_bin  = 16'h0;
         return;
      end
      do_push = 0;
      blk = 64'h0;
      if (m_pend && pipe_write) begin
         blk = {pipe_data, m_word}; do_push = 1; m_pend = 0;
      end else if (m_pend && flush) begin
         blk = {PAD, m_word}; do_push = 1; m_pend = 0;
      end else if (pipe_write && flush) begin
         blk = {PAD, pipe_data}; do_push = 1;
      end else if (pipe_write) begin
         m_word = pipe_data; m_pend = 1;
      end
      was_full = (q.size() == DEP);
      do_pop = (q.size() > 0) && blk_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         if (!was_full || do_pop) begin
            q.push_back(blk);
            m_bin = m_bin + 16'd1;
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".blk_valid"}, 64'(blk_valid), 64'(q.size() != 0));
      chk({ctx, ".level"}, 64'(level), 64'(q.size()));
      chk({ctx, ".full"}, 64'(full), 64'(q.size() == DEP));
      chk({ctx, ".empty"}, 64'(empty), 64'(q.size() == 0));
      chk({ctx, ".half_pending"}, 64'(half_pending), 64'(m_pend));
      chk({ctx, ".overflow"}, 64'(overflow), 64'(m_ovf));
      chk({ctx, ".blocks_in"}, 64'(blocks_in), 64'(m_bin));
      if (q.size() != 0) chk({ctx, ".blk_data"}, blk_data, q[0]);
   endtask

   task automatic step(input string ctx);
      model_edge();
      @(posedge okClk);
      #1;
      check_all(ctx);
   endtask

   task automatic idle();
      pipe_write = 0; flush = 0; ram_reset = 0; blk_ready = 0;
   endtask

   task automatic do_write(input logic [31:0] d, input string ctx);
      pipe_write = 1; pipe_data = d; step(ctx); pipe_write = 0;
   endtask

   task automatic do_clear(input string ctx);
      idle(); ram_reset = 1; step(ctx); ram_reset = 0;
   endtask

   task automatic drain(input string ctx);
      idle(); blk_ready = 1;
      for (int i = 0; i < DEP + 2; i++) step(ctx);
      blk_ready = 0;
   endtask

   initial begin
      // Power-on reset
      repeat (2) @(posedge okClk);
      #1;
      model_reset();
      check_all("reset");
      chk("reset.blk_data", blk_data, 64'h0);
      reset_n = 1;
      @(posedge okClk); #1;
      check_all("post_reset");

      // Single pair
      do_write(32'h0123_4567, "pair_w0");
      do_write(32'h89AB_CDEF, "pair_w1");
      chk("pair.data", blk_data, 64'h89AB_CDEF_0123_4567);
      chk("pair.level", 64'(level), 64'd1);
      drain("pair_drain");

      // Odd count with flush
      do_write(32'hAAAA_0001, "odd_a");
      do_write(32'hBBBB_0002, "odd_b");
      do_write(32'hCCCC_0003, "odd_c");
      flush = 1; step("odd_flush"); flush = 0;
      chk("odd.level", 64'(level), 64'd2);
      chk("odd.first", blk_data, 64'hBBBB_0002_AAAA_0001);
      blk_ready = 1; step("odd_pop"); blk_ready = 0;
      chk("odd.second", blk_data, {PAD, 32'hCCCC_0003});
      drain("odd_drain");

      // Fill and overflow: 34 writes = 17 blocks into a 16-deep FIFO
      do_clear("ovf_clear");
      for (int i = 0; i < 34; i++) do_write(32'h1000_0000 + 32'(i), "ovf_w");
      chk("ovf.full", 64'(full), 64'd1);
      chk("ovf.overflow", 64'(overflow), 64'd1);
      chk("ovf.blocks_in", 64'(blocks_in), 64'd16);
      drain("ovf_drain");

      // Push and pop in the same cycle while full
      do_clear("pp_clear");
      for (int i = 0; i < 32; i++) do_write(32'h2000_0000 + 32'(i), "pp_fill");
      do_write(32'h2000_00F0, "pp_low");
      blk_ready = 1;
      do_write(32'h2000_00F1, "pp_high");
      blk_ready = 0;
      chk("pp.level", 64'(level), 64'd16);
      chk("pp.overflow", 64'(overflow), 64'd0);
      drain("pp_drain");

      // Write and flush together from S_LOW
      do_clear("wf_clear");
      pipe_write = 1; flush = 1; pipe_data = 32'hDEAD_BEEF;
      step("wf"); pipe_write = 0; flush = 0;
      chk("wf.data", blk_data, 64'h0000_0000_DEAD_BEEF);
      chk("wf.half_pending", 64'(half_pending), 64'd0);
      drain("wf_drain");

      // Synchronous clear mid-operation
      for (int i = 0; i < 11; i++) do_write(32'h3000_0000 + 32'(i), "rr_fill");
      chk("rr.pre_level", 64'(level), 64'd5);
      chk("rr.pre_half", 64'(half_pending), 64'd1);
      pipe_write = 1; flush = 1; blk_ready = 1; ram_reset = 1;
      step("rr_clear");
      idle();
      chk("rr.level", 64'(level), 64'd0);
      chk("rr.empty", 64'(empty), 64'd1);
      chk("rr.blocks_in", 64'(blocks_in), 64'd0);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         pipe_write = ($urandom_range(0, 99) < 55);
         flush      = ($urandom_range(0, 99) < 15);
         blk_ready  = ($urandom_range(0, 99) < 35);
         ram_reset  = ($urandom_range(0, 199) == 0);
         pipe_data  = $urandom;
         step("rand");
      end
      idle();

      // Asynchronous reset between edges
      for (int i = 0; i < 7; i++) do_write(32'h4000_0000 + 32'(i), "ar_fill");
      @(posedge okClk);
      #3;
      model_edge();
      reset_n = 0;
      #1;
      model_reset();
      check_all("async_reset");
      chk("async_reset.blk_data", blk_data, 64'h0);
      #3;
      reset_n = 1;
      @(posedge okClk); #1;
      check_all("after_async");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
